// File: rtl/width_conv_pkg.sv
// Shared constants and elaboration-time helpers for the put/free stream width converter.
package width_conv_pkg;

  typedef enum logic {
    W2N_EMPTY = 1'b0,
    W2N_BUSY  = 1'b1
  } w2n_state_e;

  // Ratio of the wider to the narrower side; zero widths fall back to 1 so the legality check reports them.
  function automatic int unsigned conv_ratio(input int unsigned in_w, input int unsigned out_w);
    if (in_w == 0 || out_w == 0) return 1;
    return (in_w > out_w) ? in_w / out_w : out_w / in_w;
  endfunction

  function automatic int unsigned conv_cnt_w(input int unsigned in_w, input int unsigned out_w);
    return $clog2(conv_ratio(in_w, out_w) + 1);
  endfunction

  function automatic bit widths_legal(input int unsigned in_w, input int unsigned out_w);
    if (in_w == 0 || out_w == 0) return 1'b0;
    return (in_w > out_w) ? ((in_w % out_w) == 0) : ((out_w % in_w) == 0);
  endfunction

endpackage

// File: rtl/width_converter_slice_mux.sv
// Selects slice idx of a wide word; idx 0 is the bottom slice when LSB_FIRST, else the top slice.
module width_converter_slice_mux #(
  parameter  int unsigned WIDE_W    = 8,
  parameter  int unsigned SLICE_W   = 1,
  parameter  bit          LSB_FIRST = 1'b1,
  localparam int unsigned RATIO     = WIDE_W / SLICE_W,
  localparam int unsigned IDX_W     = (RATIO > 1) ? $clog2(RATIO) : 1
) (
  input  logic [WIDE_W-1:0]  word_i,
  input  logic [IDX_W-1:0]   idx_i,
  output logic [SLICE_W-1:0] slice_o
);

  always_comb begin
    slice_o = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (idx_i == IDX_W'(i)) begin
        slice_o = word_i[(LSB_FIRST ? i : RATIO - 1 - i) * SLICE_W +: SLICE_W];
      end
    end
  end

endmodule

// File: rtl/width_converter.sv
// Put/free stream width converter: wide-to-narrow serialiser, narrow-to-wide packer with flush,
// or a single registered stage when both widths match.
module width_converter
  import width_conv_pkg::*;
#(
  parameter  int unsigned INPUT_WIDTH  = 8,
  parameter  int unsigned OUTPUT_WIDTH = 1,
  parameter  bit          LSB_FIRST    = 1'b1,
  localparam int unsigned RATIO        = conv_ratio(INPUT_WIDTH, OUTPUT_WIDTH),
  localparam int unsigned CNT_W        = conv_cnt_w(INPUT_WIDTH, OUTPUT_WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    data_in_put,
  output logic                    data_in_free,
  input  logic [INPUT_WIDTH-1:0]  data_in,
  input  logic                    flush,
  output logic                    data_out_put,
  input  logic                    data_out_free,
  output logic [OUTPUT_WIDTH-1:0] data_out,
  output logic                    data_out_last,
  output logic [CNT_W-1:0]        data_out_fill
);

  if (!widths_legal(INPUT_WIDTH, OUTPUT_WIDTH)) begin : g_illegal
    $error("width_converter: widths must be >=1 and integer multiples of each other");
  end

  if (INPUT_WIDTH > OUTPUT_WIDTH) begin : g_w2n
    localparam int unsigned IDX_W = $clog2(RATIO);

    w2n_state_e               state_q, state_d;
    logic [INPUT_WIDTH-1:0]   hold_q, hold_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     in_xfer, out_xfer, out_last;
    logic                     unused_flush;

    assign unused_flush  = flush;
    assign out_last      = (state_q == W2N_BUSY) && (idx_q == IDX_W'(RATIO - 1));
    assign data_out_put  = (state_q == W2N_BUSY);
    assign data_out_last = out_last;
    assign data_out_fill = data_out_put ? CNT_W'(1) : '0;
    // The next word may load on the same cycle the last slice leaves, so streams have no bubble.
    assign data_in_free  = !reset && ((state_q == W2N_EMPTY) || (out_last && data_out_free));
    assign in_xfer       = data_in_put && data_in_free;
    assign out_xfer      = data_out_put && data_out_free;

    width_converter_slice_mux #(
      .WIDE_W    (INPUT_WIDTH),
      .SLICE_W   (OUTPUT_WIDTH),
      .LSB_FIRST (LSB_FIRST)
    ) u_slice_mux (
      .word_i  (hold_q),
      .idx_i   (idx_q),
      .slice_o (data_out)
    );

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= W2N_EMPTY;
        hold_q  <= '0;
        idx_q   <= '0;
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        idx_q   <= idx_d;
      end
    end

    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      idx_d   = idx_q;
      case (state_q)
        W2N_EMPTY: begin
          if (in_xfer) begin
            state_d = W2N_BUSY;
            hold_d  = data_in;
            idx_d   = '0;
          end
        end
        W2N_BUSY: begin
          if (out_xfer) begin
            if (out_last) begin
              idx_d = '0;
              if (in_xfer) begin
                hold_d = data_in;
              end else begin
                state_d = W2N_EMPTY;
              end
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        default: state_d = W2N_EMPTY;
      endcase
    end

  end else if (INPUT_WIDTH < OUTPUT_WIDTH) begin : g_n2w
    logic [OUTPUT_WIDTH-1:0] acc_q, acc_d, acc_n;
    logic [OUTPUT_WIDTH-1:0] out_q, out_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_n;
    logic [CNT_W-1:0]        fill_q, fill_d;
    logic                    valid_q, valid_d;
    logic                    out_room, in_xfer, emit;

    assign out_room      = !valid_q || data_out_free;
    // Only the word-completing beat needs the output register to drain.
    assign data_in_free  = !reset && (out_room || (cnt_q != CNT_W'(RATIO - 1)));
    assign in_xfer       = data_in_put && data_in_free;
    assign data_out_put  = valid_q;
    assign data_out      = out_q;
    assign data_out_last = valid_q;
    assign data_out_fill = fill_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        acc_q   <= '0;
        out_q   <= '0;
        cnt_q   <= '0;
        fill_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        acc_q   <= acc_d;
        out_q   <= out_d;
        cnt_q   <= cnt_d;
        fill_q  <= fill_d;
        valid_q <= valid_d;
      end
    end

    // Beat is merged before the flush decision so a same-cycle beat is part of the flushed word.
    always_comb begin
      acc_n = acc_q;
      cnt_n = cnt_q;
      if (in_xfer) begin
        for (int unsigned i = 0; i < RATIO; i++) begin
          if (cnt_q == CNT_W'(LSB_FIRST ? i : RATIO - 1 - i)) begin
            acc_n[i*INPUT_WIDTH +: INPUT_WIDTH] = data_in;
          end
        end
        cnt_n = cnt_q + CNT_W'(1);
      end
      emit = (cnt_n == CNT_W'(RATIO)) || (flush && (cnt_n != '0) && out_room);
      if (emit) begin
        acc_d   = '0;
        cnt_d   = '0;
        out_d   = acc_n;
        fill_d  = cnt_n;
        valid_d = 1'b1;
      end else begin
        acc_d   = acc_n;
        cnt_d   = cnt_n;
        out_d   = out_q;
        fill_d  = fill_q;
        valid_d = valid_q && !data_out_free;
      end
    end

  end else begin : g_pass
    logic [OUTPUT_WIDTH-1:0] out_q, out_d;
    logic                    valid_q, valid_d;
    logic                    in_xfer;
    logic                    unused_flush;

    assign unused_flush  = flush;
    assign data_in_free  = !reset && (!valid_q || data_out_free);
    assign in_xfer       = data_in_put && data_in_free;
    assign data_out_put  = valid_q;
    assign data_out      = out_q;
    assign data_out_last = valid_q;
    assign data_out_fill = valid_q ? CNT_W'(1) : '0;

    always_ff @(posedge clk) begin
      if (reset) begin
        out_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        out_q   <= out_d;
        valid_q <= valid_d;
      end
    end

    always_comb begin
      out_d   = out_q;
      valid_d = valid_q && !data_out_free;
      if (in_xfer) begin
        out_d   = data_in;
        valid_d = 1'b1;
      end
    end
  end

endmodule
